rx_frame_sync: RTL and testbench
================================

// Module: rx_frame_sync
// PURPOSE
//  Downstream of rx_loop_slip: consumes recovered bits (MSB first) and hunts for a sync word.
//  Frame format: SYNC(SYNC_LEN bits) | LEN(8) | LEN payload bytes | CHK(8) = XOR of LEN and all payload bytes.
//  Payload bytes go to a FIFO_DEPTH-entry FIFO with valid/ready output; frame completion is
//  flagged with a done/err strobe pair, which is the bench's end-of-test indication.
// PARAMETERS
//  SYNC_WORD    16'hD391  sync pattern, compared MSB first
//  SYNC_LEN     16        sync length in bits (<=16)
//  MAX_BIT_ERR  0         max Hamming distance accepted as a sync match
//  MAX_LEN      32        max legal LEN value (bytes)
//  FIFO_DEPTH   4         output FIFO entries (power of 2)
// PORTS
//  clk            in   1  system clock, all logic on rising edge
//  reset          in   1  asynchronous, active-high reset
//  i_bit          in   1  recovered bit
//  i_bit_valid    in   1  1-cycle strobe, i_bit valid; any spacing >=1 cycle
//  o_byte         out  8  FIFO head byte
//  o_byte_valid   out  1  FIFO non-empty
//  i_byte_ready   in   1  consumer accepts head when o_byte_valid & i_byte_ready
//  o_frame_start  out  1  1-cycle pulse, sync matched
//  o_frame_done   out  1  1-cycle pulse, frame ended (normal or error)
//  o_frame_err    out  1  1-cycle pulse with o_frame_done on any error
//  o_locked       out  1  high in states LEN/PAYLOAD/CHK
// BEHAVIOUR
//  Reset (async): state=HUNT, shift reg=0, bit count=0, FIFO flushed; all outputs 0.
//  Reset mid-frame aborts silently: no done/err pulse, queued bytes are lost.
//  States: HUNT -> LEN -> PAYLOAD -> CHK -> HUNT.
//  - HUNT: each valid bit shifts into a SYNC_LEN-bit register; fill count saturates at SYNC_LEN.
//    Match = fill==SYNC_LEN && popcount(shreg^SYNC_WORD)<=MAX_BIT_ERR, evaluated on post-shift value.
//    Match -> LEN; o_frame_start and o_locked assert the cycle after the edge sampling the last sync bit.
//  - LEN: collect 8 bits. LEN==0 or LEN>MAX_LEN -> done+err pulse, back to HUNT. Else init chk=LEN,
//    go to PAYLOAD.
//  - PAYLOAD: every 8 bits form a byte; chk^=byte; byte pushed to FIFO on the edge sampling its 8th bit;
//    after LEN bytes -> CHK.
//  - CHK: collect 8 bits. On the edge sampling the 8th: done pulses the next cycle; err also pulses if
//    received != chk. State returns to HUNT.
//  - Every return to HUNT clears shreg and fill count, so a new sync needs SYNC_LEN fresh bits.
//  - Bits with i_bit_valid=0 are ignored; the state machine never advances without a valid bit.
//  FIFO:
//  - o_byte/o_byte_valid are registered from FIFO state: a byte pushed into an empty FIFO is visible
//    the next cycle.
//  - Pop occurs when o_byte_valid & i_byte_ready; pop and push in the same cycle are both honoured,
//    including when full.
//  - Overflow: push while full without a same-cycle pop drops the byte; done+err pulse next cycle;
//    state -> HUNT.
//  - Bytes already queued are preserved and drained normally after any error; the consumer discards the
//    frame on err.
//  - Byte/bit counters: 3-bit bit index, 8-bit byte count compared against LEN; no wrap within a frame.
// TESTING
//  1 assert reset mid-payload -> all outputs 0 immediately, o_locked=0, FIFO empty, no done pulse
//  2 D391,03,11,22,33,CHK=03, ready=1 -> start pulse; bytes 11,22,33 in order; done=1, err=0; locked falls
//  3 same frame but CHK=04 -> bytes 11,22,33 emitted, then done=1 and err=1 in the same cycle
//  4 D391,LEN=00 then LEN=21 (>MAX_LEN) -> done+err each, no bytes, HUNT; next valid frame decodes
//  5 ready=0, LEN=06 -> 4 bytes held (valid=1, head=first byte); 5th byte -> done+err, HUNT; 4 bytes drain
//  6 sync D393 (1 bit err): MAX_BIT_ERR=0 -> no start; MAX_BIT_ERR=1 -> start pulse; bits 1-cycle spaced

Source files
------------

// File: rtl/rx_frame_sync.sv
// Frame synchronizer: hunts for a sync word in a recovered bit stream, then parses
// LEN | payload | XOR checksum and queues payload bytes into a small valid/ready FIFO.
module rx_frame_sync #(
  parameter logic [15:0] SYNC_WORD   = 16'hD391,
  parameter int          SYNC_LEN    = 16,
  parameter int          MAX_BIT_ERR = 0,
  parameter int          MAX_LEN     = 32,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_bit,
  input  logic       i_bit_valid,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  input  logic       i_byte_ready,
  output logic       o_frame_start,
  output logic       o_frame_done,
  output logic       o_frame_err,
  output logic       o_locked
);

  localparam int FW = $clog2(SYNC_LEN + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHK} state_e;

  state_e                state_q, state_d;
  logic [SYNC_LEN-1:0]   shreg_q, shreg_d;
  logic [FW-1:0]         fill_q, fill_d;
  logic [2:0]            bit_q, bit_d;
  logic [6:0]            sh7_q, sh7_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            bytes_q, bytes_d;
  logic [7:0]            chk_q, chk_d;
  logic                  start_q, start_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [7:0]            mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wptr_q, rptr_q;
  logic [CW-1:0]         cnt_q;

  logic [7:0]            byte_w;
  logic [SYNC_LEN-1:0]   shreg_nx, diff;
  logic [FW-1:0]         fill_nx;
  logic [4:0]            errs;
  logic                  match, push, pop, full;

  assign byte_w = {sh7_q, i_bit};
  assign pop    = (cnt_q != '0) && i_byte_ready;
  assign full   = (cnt_q == CW'(FIFO_DEPTH));

  // Sync match is judged on the value the register will hold after this bit.
  always_comb begin
    shreg_nx = SYNC_LEN'({shreg_q, i_bit});
    fill_nx  = (fill_q == FW'(SYNC_LEN)) ? fill_q : fill_q + FW'(1);
    diff     = shreg_nx ^ SYNC_WORD[SYNC_LEN-1:0];
    errs     = '0;
    for (int k = 0; k < SYNC_LEN; k++) errs = errs + 5'(diff[k]);
    match    = (fill_nx == FW'(SYNC_LEN)) && (errs <= 5'(MAX_BIT_ERR));
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    fill_d  = fill_q;
    bit_d   = bit_q;
    sh7_d   = sh7_q;
    len_d   = len_q;
    bytes_d = bytes_q;
    chk_d   = chk_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    push    = 1'b0;
    if (i_bit_valid) begin
      unique case (state_q)
        S_HUNT: begin
          shreg_d = shreg_nx;
          fill_d  = fill_nx;
          if (match) begin
            state_d = S_LEN;
            start_d = 1'b1;
            shreg_d = '0;
            fill_d  = '0;
            bit_d   = 3'd0;
          end
        end
        S_LEN: begin
          bit_d = bit_q + 3'd1;
          sh7_d = byte_w[6:0];
          if (bit_q == 3'd7) begin
            if (byte_w == 8'd0 || byte_w > 8'(MAX_LEN)) begin
              state_d = S_HUNT;
              done_d  = 1'b1;
              err_d   = 1'b1;
            end else begin
              state_d = S_PAYLOAD;
              len_d   = byte_w;
              chk_d   = byte_w;
              bytes_d = 8'd0;
            end
          end
        end
        S_PAYLOAD: begin
          bit_d = bit_q + 3'd1;
          sh7_d = byte_w[6:0];
          if (bit_q == 3'd7) begin
            // A same-cycle pop frees the slot, so only a stalled full FIFO overflows.
            if (full && !pop) begin
              state_d = S_HUNT;
              done_d  = 1'b1;
              err_d   = 1'b1;
            end else begin
              push    = 1'b1;
              chk_d   = chk_q ^ byte_w;
              bytes_d = bytes_q + 8'd1;
              if (bytes_q + 8'd1 == len_q) state_d = S_CHK;
            end
          end
        end
        S_CHK: begin
          bit_d = bit_q + 3'd1;
          sh7_d = byte_w[6:0];
          if (bit_q == 3'd7) begin
            state_d = S_HUNT;
            done_d  = 1'b1;
            err_d   = (byte_w != chk_q);
          end
        end
        default: state_d = S_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_HUNT;
      shreg_q <= '0;
      fill_q  <= '0;
      bit_q   <= '0;
      sh7_q   <= '0;
      len_q   <= '0;
      bytes_q <= '0;
      chk_q   <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      fill_q  <= fill_d;
      bit_q   <= bit_d;
      sh7_q   <= sh7_d;
      len_q   <= len_d;
      bytes_q <= bytes_d;
      chk_q   <= chk_d;
      start_q <= start_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= byte_w;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop) rptr_q <= rptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign o_byte        = mem_q[rptr_q];
  assign o_byte_valid  = (cnt_q != '0);
  assign o_frame_start = start_q;
  assign o_frame_done  = done_q;
  assign o_frame_err   = err_q;
  assign o_locked      = (state_q != S_HUNT);

endmodule

// File: tb/tb_rx_frame_sync.sv
// Bench for rx_frame_sync: frame table plus hand sequences for reset, overflow and
// sync tolerance; payload bytes are checked through an expected-byte queue.
module tb_rx_frame_sync;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_bit = 1'b0, i_bit_valid = 1'b0, i_byte_ready = 1'b1;
  logic [7:0] o_byte, o_byte1;
  logic       o_byte_valid, o_frame_start, o_frame_done, o_frame_err, o_locked;
  logic       o_byte_valid1, o_frame_start1, o_frame_done1, o_frame_err1, o_locked1;

  rx_frame_sync #(.MAX_BIT_ERR(0)) dut0 (
    .clk(clk), .reset(reset), .i_bit(i_bit), .i_bit_valid(i_bit_valid),
    .o_byte(o_byte), .o_byte_valid(o_byte_valid), .i_byte_ready(i_byte_ready),
    .o_frame_start(o_frame_start), .o_frame_done(o_frame_done),
    .o_frame_err(o_frame_err), .o_locked(o_locked));

  rx_frame_sync #(.MAX_BIT_ERR(1)) dut1 (
    .clk(clk), .reset(reset), .i_bit(i_bit), .i_bit_valid(i_bit_valid),
    .o_byte(o_byte1), .o_byte_valid(o_byte_valid1), .i_byte_ready(1'b1),
    .o_frame_start(o_frame_start1), .o_frame_done(o_frame_done1),
    .o_frame_err(o_frame_err1), .o_locked(o_locked1));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int start0 = 0, done0 = 0, err0 = 0, start1 = 0, pops = 0;
  int gap = 0;
  logic [7:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (o_frame_start)  start0++;
      if (o_frame_done)   done0++;
      if (o_frame_err)    err0++;
      if (o_frame_start1) start1++;
      if (o_frame_err) check("err_with_done", o_frame_done, 1);
      if (o_byte_valid && i_byte_ready) begin
        pops++;
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_byte: got %0h expected none", o_byte);
        end else begin
          logic [7:0] e;
          e = sb.pop_front();
          check("byte", o_byte, e);
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    i_bit = b;
    i_bit_valid = 1'b1;
    @(posedge clk); #1;
    i_bit_valid = 1'b0;
    i_bit = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_word16(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 200 && (sb.size() != 0 || o_byte_valid); k++) begin
      @(posedge clk); #1;
    end
    check(name, sb.size(), 0);
  endtask

  typedef struct {
    logic [7:0] len;
    logic [7:0] seed;
    logic       bad_chk;
    int         gap;
    logic       exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, d0, e0, s1, p0, nb;
    logic [7:0] c, b;

    vecs[0] = '{8'h03, 8'h11, 1'b0, 0, 1'b0};
    vecs[1] = '{8'h03, 8'h11, 1'b1, 1, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b0, 0, 1'b1};
    vecs[3] = '{8'h21, 8'h00, 1'b0, 0, 1'b1};
    vecs[4] = '{8'h02, 8'hAA, 1'b0, 2, 1'b0};
    vecs[5] = '{8'h20, 8'h01, 1'b0, 0, 1'b0};
    vecs[6] = '{8'h01, 8'h00, 1'b0, 0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_byte", o_byte, 0);
    check("rst_valid", o_byte_valid, 0);
    check("rst_start", o_frame_start, 0);
    check("rst_done", o_frame_done, 0);
    check("rst_err", o_frame_err, 0);
    check("rst_locked", o_locked, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a payload with one byte queued.
    i_byte_ready = 1'b0;
    gap = 0;
    send_word16(16'hD391);
    check("sync_locked", o_locked, 1);
    send_byte(8'h03);
    send_byte(8'h5A);
    check("mid_valid", o_byte_valid, 1);
    send_bit(1'b1);
    send_bit(1'b0);
    d0 = done0;
    #2 reset = 1'b1;
    #1;
    check("arst_byte", o_byte, 0);
    check("arst_valid", o_byte_valid, 0);
    check("arst_locked", o_locked, 0);
    check("arst_done", o_frame_done, 0);
    check("arst_err", o_frame_err, 0);
    #2 reset = 1'b0;
    i_byte_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("arst_no_done", done0 - d0, 0);
    check("arst_fifo_empty", o_byte_valid, 0);

    foreach (vecs[i]) begin
      s0 = start0; d0 = done0; e0 = err0; s1 = start1; p0 = pops; nb = 0;
      gap = vecs[i].gap;
      send_word16(16'hD391);
      send_byte(vecs[i].len);
      if (vecs[i].len != 8'd0 && vecs[i].len <= 8'd32) begin
        c = vecs[i].len;
        for (int j = 0; j < int'(vecs[i].len); j++) begin
          b = vecs[i].seed + 8'(j * 8'h11);
          sb.push_back(b);
          c = c ^ b;
          send_byte(b);
          nb++;
        end
        send_byte(vecs[i].bad_chk ? (c ^ 8'h07) : c);
      end
      for (int k = 0; k < 50 && done0 == d0; k++) begin @(posedge clk); #1; end
      check($sformatf("v%0d_locked", i), o_locked, 0);
      drain($sformatf("v%0d_drain", i));
      check($sformatf("v%0d_start", i), start0 - s0, 1);
      check($sformatf("v%0d_done", i), done0 - d0, 1);
      check($sformatf("v%0d_err", i), err0 - e0, vecs[i].exp_err);
      check($sformatf("v%0d_bytes", i), pops - p0, nb);
      check($sformatf("v%0d_start_tol", i), start1 - s1, 1);
    end

    // Stalled consumer: four bytes fill the FIFO, the fifth overflows.
    i_byte_ready = 1'b0;
    gap = 0;
    d0 = done0; e0 = err0; p0 = pops;
    send_word16(16'hD391);
    send_byte(8'h06);
    for (int j = 0; j < 4; j++) begin
      b = 8'hC0 + 8'(j);
      sb.push_back(b);
      send_byte(b);
    end
    check("ovf_valid", o_byte_valid, 1);
    check("ovf_head", o_byte, 8'hC0);
    send_byte(8'hC4);
    check("ovf_done_pulse", o_frame_done, 1);
    check("ovf_err_pulse", o_frame_err, 1);
    check("ovf_unlocked", o_locked, 0);
    check("ovf_head_kept", o_byte, 8'hC0);
    @(posedge clk); #1;
    i_byte_ready = 1'b1;
    drain("ovf_drain");
    check("ovf_bytes", pops - p0, 4);
    check("ovf_done_cnt", done0 - d0, 1);
    check("ovf_err_cnt", err0 - e0, 1);

    // One-bit sync error: only the tolerant instance locks.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    s0 = start0; s1 = start1;
    gap = 0;
    send_word16(16'hD393);
    repeat (2) @(posedge clk);
    #1;
    check("tol0_start", start0 - s0, 0);
    check("tol1_start", start1 - s1, 1);
    check("tol0_locked", o_locked, 0);
    check("tol1_locked", o_locked1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
